// File: rtl/mem_write_checker.sv
// In-order monitor of data-memory writes against a loadable table of expected (addr,data) pairs.
// Reports pass, strict-mode fail or timeout; status flags are registered together with the state.
module mem_write_checker #(
   parameter int               WIDTH       = 32,
   parameter int               DEPTH       = 8,
   parameter int               TIMEOUT     = 300,
   parameter int               STRICT      = 0,
   parameter int               IGNORE_EN   = 1,
   parameter logic [WIDTH-1:0] IGNORE_ADDR = WIDTH'(84)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load_en,
   input  logic [WIDTH-1:0]           load_addr,
   input  logic [WIDTH-1:0]           load_data,
   input  logic                       start,
   input  logic                       clr,
   input  logic                       memwrite,
   input  logic [WIDTH-1:0]           dataadr,
   input  logic [WIDTH-1:0]           writedata,
   output logic                       busy,
   output logic                       pass,
   output logic                       fail,
   output logic                       timeout,
   output logic                       table_full,
   output logic [$clog2(DEPTH+1)-1:0] match_count,
   output logic [WIDTH-1:0]           fail_addr,
   output logic [WIDTH-1:0]           fail_data,
   output logic [15:0]                cycle_count
);

   localparam int            CW       = $clog2(DEPTH + 1);
   localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            SLOTS    = 1 << IW;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [15:0]   LIMIT_C  = 16'(TIMEOUT - 1);
   localparam bit            STRICT_B = (STRICT != 0);
   localparam bit            IGNORE_B = (IGNORE_EN != 0);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [CW-1:0]    rd_ptr;
   logic [CW-1:0]    count_loaded;
   logic [WIDTH-1:0] tbl_addr [SLOTS];
   logic [WIDTH-1:0] tbl_data [SLOTS];
   logic             load_ok;
   logic             hit;
   logic             last_entry;
   logic             ignored;
   logic             strict_miss;
   logic             at_limit;

   // A load in the same cycle as start is already counted when deciding RUN vs. immediate PASS.
   assign load_ok      = (state == S_IDLE) && load_en && (count < DEPTH_C);
   assign count_loaded = load_ok ? count + CW'(1) : count;

   assign hit         = memwrite
                        && (dataadr == tbl_addr[rd_ptr[IW-1:0]])
                        && (writedata == tbl_data[rd_ptr[IW-1:0]]);
   assign last_entry  = (rd_ptr == count - CW'(1));
   assign ignored     = IGNORE_B && (dataadr == IGNORE_ADDR);
   assign strict_miss = STRICT_B && memwrite && !hit && !ignored;
   assign at_limit    = (cycle_count == LIMIT_C);

   assign table_full  = (count == DEPTH_C);
   assign match_count = rd_ptr;

   // Expected-write table; contents survive reset, only the entry count is cleared.
   always_ff @(posedge clk) begin
      if (!reset && !clr && load_ok) begin
         tbl_addr[count[IW-1:0]] <= load_addr;
         tbl_data[count[IW-1:0]] <= load_data;
      end
   end

   // Checker FSM: clr behaves like reset; start from IDLE or any finished state re-arms the run.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         state       <= S_IDLE;
         count       <= '0;
         rd_ptr      <= '0;
         cycle_count <= '0;
         fail_addr   <= '0;
         fail_data   <= '0;
         busy        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               if (cycle_count != 16'hFFFF) begin
                  cycle_count <= cycle_count + 16'd1;
               end
               if (hit) begin
                  rd_ptr <= rd_ptr + CW'(1);
               end
               // A completing match or a strict miss outranks the timeout on the same edge.
               if (hit && last_entry) begin
                  state <= S_PASS;
                  busy  <= 1'b0;
                  pass  <= 1'b1;
               end else if (strict_miss) begin
                  state     <= S_FAIL;
                  busy      <= 1'b0;
                  fail      <= 1'b1;
                  fail_addr <= dataadr;
                  fail_data <= writedata;
               end else if (at_limit) begin
                  state   <= S_TMO;
                  busy    <= 1'b0;
                  timeout <= 1'b1;
               end
            end
            default: begin
               if (load_ok) begin
                  count <= count_loaded;
               end
               if (start) begin
                  rd_ptr      <= '0;
                  cycle_count <= '0;
                  fail_addr   <= '0;
                  fail_data   <= '0;
                  fail        <= 1'b0;
                  timeout     <= 1'b0;
                  if (count_loaded == '0) begin
                     state <= S_PASS;
                     busy  <= 1'b0;
                     pass  <= 1'b1;
                  end else begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                     pass  <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

endmodule
